// File: rtl/pulse_scheduler.sv
// Round-robin scheduler for a shared fixed-width pulse line.
// One granted request yields one PULSE_LEN-cycle pulse, a one-cycle ack and a GAP_LEN guard gap.
module pulse_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_pulse_out,
    output logic [$clog2(NUM_REQ)-1:0] o_sel,
    output logic                       o_busy
);

    localparam int unsigned SW     = $clog2(NUM_REQ);
    localparam int unsigned MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CW     = $clog2(MAXLEN + 1);

    localparam logic [CW-1:0] PulseInit = CW'(PULSE_LEN - 1);
    // GAP_LEN=0 never loads the gap counter; the guard only keeps the constant in range.
    localparam logic [CW-1:0] GapInit   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
    localparam logic [SW-1:0] LastInit  = SW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                r_pulse;
    logic                w_pulse_next;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic [SW-1:0]       r_sel;
    logic [SW-1:0]       w_sel_next;
    logic [SW-1:0]       r_last;
    logic [SW-1:0]       w_last_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                w_any_req;
    logic [SW-1:0]       w_winner;

    // Pick the first requester searching upward from last+1 with wrap-around.
    // Iterating from the farthest offset down leaves the nearest set bit as the winner.
    always_comb begin
        w_any_req = |i_req;
        w_winner  = r_last;
        for (int i = int'(NUM_REQ); i > 0; i--) begin
            if (i_req[(int'(r_last) + i) % int'(NUM_REQ)]) begin
                w_winner = SW'((int'(r_last) + i) % int'(NUM_REQ));
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pulse_next = r_pulse;
        w_ack_next   = '0;
        w_sel_next   = r_sel;
        w_last_next  = r_last;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StPulse;
                    w_pulse_next = 1'b1;
                    w_sel_next   = w_winner;
                    w_last_next  = w_winner;
                    w_cnt_next   = PulseInit;
                end
            end
            StPulse: begin
                if (r_cnt == '0) begin
                    w_pulse_next      = 1'b0;
                    w_ack_next[r_sel] = 1'b1;
                    if (GAP_LEN > 0) begin
                        w_state_next = StGap;
                        w_cnt_next   = GapInit;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == '0) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_pulse_next = 1'b0;
            end
        endcase
        w_busy_next = (w_state_next != StIdle);
    end

    // State and output registers; reset drops the pulse line immediately.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_ack   <= '0;
            r_sel   <= '0;
            r_last  <= LastInit;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_pulse_next;
            r_ack   <= w_ack_next;
            r_sel   <= w_sel_next;
            r_last  <= w_last_next;
            r_busy  <= w_busy_next;
        end
    end

    assign o_ack       = r_ack;
    assign o_pulse_out = r_pulse;
    assign o_sel       = r_sel;
    assign o_busy      = r_busy;

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Round-robin scheduler sharing a single fixed-width pulse output between several requesters, such as the camera trigger and the framebuffer write strobe. Each granted request produces exactly one pulse of PULSE_LEN cycles on the shared line, followed by a guard gap of at least GAP_LEN cycles. The block sits between the requesting control FSMs and the `pulse` stage that consumes the strobe, and guarantees that pulses never overlap.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- PULSE_LEN, 4: pulse width in clk cycles, ≥1.
- GAP_LEN, 2: minimum idle cycles after each pulse, ≥0.
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NUM_REQ  level request per requester; held high until acked.
- ack  output  NUM_REQ  one-hot, one-cycle acknowledge of the completed pulse.
- pulse_out  output  1  shared pulse line.
- sel  output  $clog2(NUM_REQ)  index of the requester owning the current pulse.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- FSM with three states: IDLE, PULSE, GAP. All outputs are registered.
- Reset (reset=0) applies asynchronously: state=IDLE, pulse_out=0, ack=0, busy=0, sel=0, counter=0, last-grant pointer=NUM_REQ-1, so requester 0 has top priority after reset.
- IDLE: if any req bit is high, pick the first set bit searching upward from (last+1) mod NUM_REQ with wrap-around. On the next edge: state=PULSE, pulse_out=1, sel=winner, last=winner, counter=PULSE_LEN-1, busy=1.
- PULSE: decrement the counter each cycle. While counter=0:
  - on the next edge pulse_out=0 and ack[sel]=1 for exactly one cycle;
  - state goes to GAP with counter=GAP_LEN-1 if GAP_LEN>0, else to IDLE.
- GAP: decrement the counter. When counter=0, the next edge moves state to IDLE.
- No arbitration takes place outside IDLE. New requests wait in IDLE for the next decision.
- Requesters must deassert req on the edge following ack. A req still high in the first IDLE cycle counts as a new request.
- A req dropped mid-pulse does not shorten the pulse: the pulse completes and ack is still issued.
- sel holds its value through PULSE and GAP, and after returning to IDLE, until the next grant.
- The counter is $clog2(max(PULSE_LEN,GAP_LEN)+1) bits wide and is unsigned with no wrap. Reaching 0 only triggers the state transition and never decrements below 0.

## Timing
- Request sampled high in IDLE at edge E: pulse_out is high for edges E+1..E+PULSE_LEN inclusive.
- ack[sel] is high for the single cycle starting at edge E+PULSE_LEN+1, coincident with pulse_out falling.
- busy rises at E+1. It falls at E+PULSE_LEN+GAP_LEN+1; with GAP_LEN=0 it falls at E+PULSE_LEN+1.
- Minimum grant-to-grant spacing is PULSE_LEN+GAP_LEN+1 cycles, because one IDLE decision cycle is always present.
- Simultaneous requests: only one is granted per decision and the others stay pending. With all req high continuously, grants are issued in order 0,1,2,3,0,…
- Reset asserted mid-PULSE: pulse_out drops immediately (asynchronously), no ack is issued, and the pointer returns to NUM_REQ-1.
- Reset release: the first possible grant is on the first edge after reset goes high, with pulse_out high one edge later.

## Test plan
- Single request, defaults: req[2]=1 at edge 10 → pulse_out high at edges 11–14, sel=2, ack=4'b0100 at edge 15, busy low from edge 17.
- All four req held high (each requester drops on ack, then reasserts) → sel sequence 0,1,2,3,0 with pulses starting every 7 cycles; no two pulses overlap and pulse_out has at least 2 low cycles between pulses.
- Round-robin pointer: grant 1, then raise req[0] and req[3] together in IDLE → requester 3 is granted before requester 0.
- GAP_LEN=0, PULSE_LEN=1, req[0] held continuously → pulse_out 1,0,1,0…, ack[0] on every second cycle, busy never low for more than 1 cycle.
- Req dropped at the 2nd pulse cycle → pulse_out still high for 4 cycles and ack issued normally.
- reset=0 at the 2nd cycle of a pulse → pulse_out, busy and ack are 0 within the same cycle. After release with req[1]=1, a normal 4-cycle pulse follows with sel=1.
